// File: rtl/sync_filter_pkg.sv
// Purpose: shared constants and helpers for the synchronise-and-debounce filter bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default parameter values, legal parameter ranges, glitch counter sizing, clog2.
package sync_filter_pkg;

  localparam int N_CH_DEFAULT        = 4;
  localparam int SYNC_STAGES_DEFAULT = 2;
  localparam int FILT_CYCLES_DEFAULT = 4;

  localparam int N_CH_MIN        = 1;
  localparam int N_CH_MAX        = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILT_CYCLES_MIN = 1;
  localparam int FILT_CYCLES_MAX = 255;

  localparam int GLITCH_W = 8;
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'hFF;

  // Ceiling log2; the callers always pass values >= 2, so the result is >= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// Purpose: one channel -- metastability synchroniser, stability counter, debounced level, edge pulses.
// Latency: SYNC_STAGES edges to sync_out, then FILT_CYCLES more edges to filt_out and the pulse.
// Backpressure: none; the channel samples every cycle and never stalls.
// Ports: clk/reset (sync, active-high); async_in raw level; sync_out last synchroniser stage;
//        filt_out debounced level; rise_pulse/fall_pulse one-cycle edge strobes;
//        glitch high in any cycle where a partial count is being abandoned.
module sync_filter_ch
  import sync_filter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int FILT_CYCLES = FILT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic filt_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic glitch
);

  localparam int CW = clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   differ;
  logic                   load;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign differ   = (sync_out != filt_out);
  // The cycle that completes FILT_CYCLES consecutive mismatches commits the new level.
  assign load     = differ && (cnt == CNT_LAST);
  // Input settled back to the accepted level before the count completed.
  assign glitch   = !differ && (cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      filt_out   <= 1'b0;
      cnt        <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      if (load) begin
        filt_out <= sync_out;
        cnt      <= '0;
      end else if (differ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      // Registered alongside filt_out so the strobe coincides with the new level.
      rise_pulse <= load && sync_out;
      fall_pulse <= load && !sync_out;
    end
  end

endmodule

// File: rtl/sync_filter_bank.sv
// Purpose: bank of N_CH independent synchronise-and-debounce channels with a shared glitch counter.
// Latency: SYNC_STAGES + FILT_CYCLES edges from an async_in step to filt_out and its pulse.
// Backpressure: none; every channel evaluates every cycle.
// Ports: clk/reset (sync, active-high); async_in[N_CH] raw levels; sync_out/filt_out per channel;
//        rise_pulse/fall_pulse per channel; change_any OR of all pulses;
//        glitch_cnt saturating count of cycles with at least one abandoned count.
module sync_filter_bank
  import sync_filter_pkg::*;
#(
  parameter int N_CH        = N_CH_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int FILT_CYCLES = FILT_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CH-1:0]     async_in,
  output logic [N_CH-1:0]     sync_out,
  output logic [N_CH-1:0]     filt_out,
  output logic [N_CH-1:0]     rise_pulse,
  output logic [N_CH-1:0]     fall_pulse,
  output logic                change_any,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  if ((N_CH < N_CH_MIN) || (N_CH > N_CH_MAX) ||
      (SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX) ||
      (FILT_CYCLES < FILT_CYCLES_MIN) || (FILT_CYCLES > FILT_CYCLES_MAX)) begin : g_bad_param
    $error("sync_filter_bank: parameter out of legal range");
  end

  logic [N_CH-1:0] glitch;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sync_filter_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .async_in  (async_in[i]),
      .sync_out  (sync_out[i]),
      .filt_out  (filt_out[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i]),
      .glitch    (glitch[i])
    );
  end

  // Pulses are already registered, so this OR adds no cycle of delay.
  assign change_any = |(rise_pulse | fall_pulse);

  // One count per cycle no matter how many channels glitch together.
  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_cnt <= '0;
    end else if ((|glitch) && (glitch_cnt != GLITCH_MAX)) begin
      glitch_cnt <= glitch_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sync_filter_bank.sv
module tb_sync_filter_bank;

  logic       clk;
  logic       reset;
  logic [3:0] async_in;
  logic [3:0] sync_out;
  logic [3:0] filt_out;
  logic [3:0] rise_pulse;
  logic [3:0] fall_pulse;
  logic       change_any;
  logic [7:0] glitch_cnt;

  int tests;
  int fails;

  typedef struct {
    logic       rst;
    logic [3:0] a;
    int         reps;
    logic [3:0] s;
    logic [3:0] f;
    logic [3:0] rp;
    logic [3:0] fp;
    logic       ca;
    logic [7:0] g;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  sync_filter_bank #(
    .N_CH(4),
    .SYNC_STAGES(2),
    .FILT_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .async_in  (async_in),
    .sync_out  (sync_out),
    .filt_out  (filt_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .change_any(change_any),
    .glitch_cnt(glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] pack_exp(input vec_t v);
    return {v.s, v.f, v.rp, v.fp, v.ca, v.g};
  endfunction

  task automatic check_outputs(input string name);
    vec_t        e;
    logic [24:0] act;
    logic [24:0] exp;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e   = sb.pop_front();
    exp = pack_exp(e);
    act = {sync_out, filt_out, rise_pulse, fall_pulse, change_any, glitch_cnt};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got sync=%h filt=%h rise=%h fall=%h any=%b gcnt=%0d want sync=%h filt=%h rise=%h fall=%h any=%b gcnt=%0d",
               name, sync_out, filt_out, rise_pulse, fall_pulse, change_any, glitch_cnt,
               e.s, e.f, e.rp, e.fp, e.ca, e.g);
    end
    tests++;
    if ((rise_pulse & fall_pulse) !== 4'h0) begin
      fails++;
      $display("FAIL %s_exclusive rise=%h fall=%h want no overlap", name, rise_pulse, fall_pulse);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] a, input int n,
                     input logic [3:0] s, input logic [3:0] f, input logic [3:0] rp,
                     input logic [3:0] fp, input logic ca, input logic [7:0] g);
    vec_t v;
    v.rst = r; v.a = a; v.reps = n; v.s = s; v.f = f;
    v.rp = rp; v.fp = fp; v.ca = ca; v.g = g;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t v;
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    async_in = 4'hF;

    //  rst  a    reps sync filt rise fall any gcnt   (expectation after each edge)
    // Reset held with inputs high, then release: sync after edge 2, filt after edge 6.
    add(1, 4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);
    add(0, 4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);
    add(0, 4'hF, 4, 4'hF, 4'h0, 4'h0, 4'h0, 0, 8'd0);
    add(0, 4'hF, 1, 4'hF, 4'hF, 4'hF, 4'h0, 1, 8'd0);
    add(0, 4'hF, 1, 4'hF, 4'hF, 4'h0, 4'h0, 0, 8'd0);
    // Reset forcing filt 1->0 must not raise fall_pulse.
    add(1, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);
    // Two-cycle glitch on ch0.
    add(0, 4'h1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);
    add(0, 4'h1, 1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 8'd0);
    add(0, 4'h0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 0, 8'd0);
    add(0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);
    add(0, 4'h0, 2, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd1);
    // Three-cycle pulse on ch1: one short of threshold.
    add(0, 4'h2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd1);
    add(0, 4'h2, 2, 4'h2, 4'h0, 4'h0, 4'h0, 0, 8'd1);
    add(0, 4'h0, 1, 4'h2, 4'h0, 4'h0, 4'h0, 0, 8'd1);
    add(0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd1);
    add(0, 4'h0, 2, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd2);
    // Four-cycle pulse on ch1: accepted, fall follows rise by 4 cycles.
    add(0, 4'h2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd2);
    add(0, 4'h2, 3, 4'h2, 4'h0, 4'h0, 4'h0, 0, 8'd2);
    add(0, 4'h0, 1, 4'h2, 4'h0, 4'h0, 4'h0, 0, 8'd2);
    add(0, 4'h0, 1, 4'h0, 4'h2, 4'h2, 4'h0, 1, 8'd2);
    add(0, 4'h0, 3, 4'h0, 4'h2, 4'h0, 4'h0, 0, 8'd2);
    add(0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h2, 1, 8'd2);
    add(0, 4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd2);
    // ch3 settles high, then ch2 rises while ch3 falls in the same cycle.
    add(0, 4'h8, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd2);
    add(0, 4'h8, 4, 4'h8, 4'h0, 4'h0, 4'h0, 0, 8'd2);
    add(0, 4'h8, 1, 4'h8, 4'h8, 4'h8, 4'h0, 1, 8'd2);
    add(0, 4'h8, 1, 4'h8, 4'h8, 4'h0, 4'h0, 0, 8'd2);
    add(0, 4'h4, 1, 4'h8, 4'h8, 4'h0, 4'h0, 0, 8'd2);
    add(0, 4'h4, 4, 4'h4, 4'h8, 4'h0, 4'h0, 0, 8'd2);
    add(0, 4'h4, 1, 4'h4, 4'h4, 4'h4, 4'h8, 1, 8'd2);
    add(0, 4'h4, 1, 4'h4, 4'h4, 4'h0, 4'h0, 0, 8'd2);
    // ch0 counts to 2, then reset lands mid-count; afresh count needs the full 6 edges.
    add(0, 4'h5, 1, 4'h4, 4'h4, 4'h0, 4'h0, 0, 8'd2);
    add(0, 4'h5, 3, 4'h5, 4'h4, 4'h0, 4'h0, 0, 8'd2);
    add(1, 4'h5, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);
    add(0, 4'h1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);
    add(0, 4'h1, 4, 4'h1, 4'h0, 4'h0, 4'h0, 0, 8'd0);
    add(0, 4'h1, 1, 4'h1, 4'h1, 4'h1, 4'h0, 1, 8'd0);
    add(0, 4'h1, 1, 4'h1, 4'h1, 4'h0, 4'h0, 0, 8'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        @(negedge clk);
        reset    = tbl[i].rst;
        async_in = tbl[i].a;
        sb.push_back(tbl[i]);
        @(posedge clk);
        #1;
        check_outputs($sformatf("vec%0d_%0d", i, r));
      end
    end

    // Saturation: 300 rejected two-cycle glitches on ch1 while ch0 stays high.
    for (int k = 1; k <= 300; k++) begin
      v.rst = 0; v.a = 4'h1; v.reps = 1; v.s = 4'h1; v.f = 4'h1;
      v.rp = 4'h0; v.fp = 4'h0; v.ca = 1'b0;
      v.g = (k > 255) ? 8'd255 : 8'(k);
      sb.push_back(v);
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        reset    = 1'b0;
        async_in = (c < 2) ? 4'h3 : 4'h1;
      end
      @(posedge clk);
      #1;
      check_outputs($sformatf("sat%0d", k));
    end

    // Idle cycles: the saturated count holds.
    for (int c = 0; c < 3; c++) begin
      v.rst = 0; v.a = 4'h1; v.reps = 1; v.s = 4'h1; v.f = 4'h1;
      v.rp = 4'h0; v.fp = 4'h0; v.ca = 1'b0; v.g = 8'd255;
      @(negedge clk);
      async_in = 4'h1;
      sb.push_back(v);
      @(posedge clk);
      #1;
      check_outputs($sformatf("hold%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_filter_bank.md
SYNC_FILTER_BANK -- requirements
Module: sync_filter_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent asynchronous input channels, legal range 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flop depth per channel, legal range 2..4.
REQ-003 SHALL have parameter FILT_CYCLES, default 4: consecutive stable cycles needed to accept a level change, legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all flops update on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-006 SHALL have port async_in, input, N_CH bits: asynchronous level inputs.
REQ-007 SHALL have port sync_out, output, N_CH bits: last synchroniser stage per channel, unfiltered.
REQ-008 SHALL have port filt_out, output, N_CH bits: debounced level per channel.
REQ-009 SHALL have port rise_pulse, output, N_CH bits: one-cycle pulse on each filt_out 0->1.
REQ-010 SHALL have port fall_pulse, output, N_CH bits: one-cycle pulse on each filt_out 1->0.
REQ-011 SHALL have port change_any, output, 1 bit: OR of all rise_pulse and fall_pulse bits.
REQ-012 SHALL have port glitch_cnt, output, 8 bits: saturating count of rejected glitches.

Function
REQ-013 Each channel SHALL pass async_in through a SYNC_STAGES-deep flop chain; sync_out SHALL equal the last stage.
REQ-014 A level held on async_in before edge 1 SHALL appear on sync_out after edge SYNC_STAGES.
REQ-015 Each channel SHALL hold a stability counter of width clog2(FILT_CYCLES+1).
REQ-016 When sync_out != filt_out and cnt == FILT_CYCLES-1, filt_out SHALL load sync_out and cnt SHALL clear.
REQ-017 When sync_out != filt_out and cnt < FILT_CYCLES-1, cnt SHALL increment.
REQ-018 When sync_out == filt_out, cnt SHALL clear.
REQ-019 Total latency from the async_in step to the filt_out change SHALL be exactly SYNC_STAGES+FILT_CYCLES edges.
REQ-020 With FILT_CYCLES=1, filt_out SHALL follow sync_out with one cycle of delay.
REQ-021 rise_pulse[i] and fall_pulse[i] SHALL be registered and SHALL be high during exactly the cycle in which filt_out[i] first shows its new value.
REQ-022 rise_pulse[i] and fall_pulse[i] SHALL never be high together.
REQ-023 change_any SHALL be combinational from the registered pulses; it adds no latency.
REQ-024 A glitch SHALL be defined per cycle as any channel with sync_out == filt_out and cnt != 0, i.e. an abandoned count.
REQ-025 glitch_cnt SHALL increment by 1 per cycle in which at least one channel has a glitch, regardless of how many channels do.
REQ-026 glitch_cnt SHALL saturate at 255 and SHALL clear only by reset.
REQ-027 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.

Reset
REQ-028 On any rising edge with reset=1, all synchroniser stages, filt_out, cnt, rise_pulse, fall_pulse and glitch_cnt SHALL become 0.
REQ-029 Reset SHALL take priority over all other updates, including a pending count.
REQ-030 Forcing filt_out to 0 by reset SHALL NOT generate fall_pulse.
REQ-031 After reset releases, filtering SHALL restart from cnt=0 with no memory of pre-reset counts.

Structure
REQ-032 A shared package sync_filter_pkg SHALL hold the default parameter constants, the legal-range limits and a clog2 function.
REQ-033 Per-channel logic SHALL live in sub-module sync_filter_ch, covering the sync chain, counter, filt_out and pulses.
REQ-034 The top level SHALL instantiate sync_filter_ch N_CH times via generate and SHALL own change_any and glitch_cnt.

Verification
Settings: N_CH=4, SYNC_STAGES=2, FILT_CYCLES=4.
REQ-035 Reset: reset=1 for 3 cycles with async_in=4'hF -> all outputs 0 and no pulses during reset; release -> sync_out=4'hF after edge 2, filt_out=4'hF with rise_pulse=4'hF and change_any=1 for one cycle after edge 6.
REQ-036 Glitch: async_in[0] high for 2 cycles then low -> sync_out[0] high for 2 cycles, filt_out[0] stays 0, glitch_cnt 0->1.
REQ-037 Threshold boundary: 3-cycle pulse on ch1 -> rejected, glitch_cnt +1; 4-cycle pulse on ch1 -> rise_pulse[1] after edge 6, then fall_pulse[1] exactly 4 cycles later.
REQ-038 Simultaneous: ch2 rises and ch3 falls in the same cycle (ch3 previously stable high) -> rise_pulse[2] and fall_pulse[3] high in the same single cycle, change_any high for that one cycle.
REQ-039 Reset mid-count: assert reset while ch0 cnt=2 -> filt_out[0] stays 0, no pulse, cnt=0 after release.
REQ-040 Saturation: 300 rejected 2-cycle glitches -> glitch_cnt=255 and holds at 255.
